// File: rtl/serial_word_deframer_pkg.sv
// Shared types and constants for the serial word deframer and its neighbouring
// serializer/register stages.
package serial_word_deframer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // A WIDTH of 1 is illegal for the deframer, but keep the counter at least 1 bit wide.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_word_deframer_sipo_shift_core.sv
// Serial-in/parallel-out shift register with bit counter; word_next is the word
// as it will be after the current bit is shifted in, last_bit flags the final bit.
module sipo_shift_core
    import serial_word_deframer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             serial_data,
    output logic             last_bit,
    output logic [WIDTH-1:0] word_next
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    count;

    // A true shift places bit k correctly after WIDTH shifts, so stale bits from an
    // aborted frame are always pushed out before a frame completes.
    generate
        if (MSB_FIRST) begin : g_msb
            assign word_next = {sreg[WIDTH-2:0], serial_data};
        end else begin : g_lsb
            assign word_next = {serial_data, sreg[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg  <= '0;
            count <= '0;
        end else if (clear) begin
            sreg  <= '0;
            count <= '0;
        end else if (shift_en) begin
            sreg  <= word_next;
            count <= last_bit ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_word_deframer.sv
// Reassembles load/shift serial frames into words on a valid/ready output; word
// appears the cycle after its last bit, and a frame completing against a stalled word is dropped (sticky overrun).
module serial_word_deframer
    import serial_word_deframer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             input_clk,
    input  logic             input_rst,
    input  logic             input_load_shift,
    input  logic             input_serial_data,
    input  logic             input_ready,
    output logic [WIDTH-1:0] output_word,
    output logic             output_valid,
    output logic             output_frame_error,
    output logic             output_overrun,
    output logic             output_busy
);

    state_t           state;
    logic             shift_en;
    logic             clear;
    logic             last_bit;
    logic [WIDTH-1:0] word_next;

    assign shift_en    = !input_load_shift && (state == ST_ARMED || state == ST_SHIFT);
    assign clear       = input_load_shift && (state == ST_SHIFT);
    assign output_busy = (state != ST_IDLE);

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk         (input_clk),
        .rst         (input_rst),
        .shift_en    (shift_en),
        .clear       (clear),
        .serial_data (input_serial_data),
        .last_bit    (last_bit),
        .word_next   (word_next)
    );

    always_ff @(posedge input_clk or posedge input_rst) begin
        if (input_rst) begin
            state              <= ST_IDLE;
            output_word        <= '0;
            output_valid       <= 1'b0;
            output_frame_error <= 1'b0;
            output_overrun     <= 1'b0;
        end else begin
            output_frame_error <= 1'b0;
            if (output_valid && input_ready) begin
                output_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (input_load_shift) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (!input_load_shift) state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (input_load_shift) begin
                        state              <= ST_ARMED;
                        output_frame_error <= 1'b1;
                    end else if (last_bit) begin
                        state <= ST_IDLE;
                        // Accept the new word only if the slot is empty or draining this edge.
                        if (!output_valid || input_ready) begin
                            output_word  <= word_next;
                            output_valid <= 1'b1;
                        end else begin
                            output_overrun <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_deframer.sv
// Directed bench driving an MSB-first and an LSB-first deframer with the same serial stream.
module tb_serial_word_deframer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_shift;
    logic       serial_data;
    logic       ready;

    logic [3:0] word_m, word_l;
    logic       valid_m, valid_l;
    logic       ferr_m, ferr_l;
    logic       ovr_m, ovr_l;
    logic       busy_m, busy_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_word_deframer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .input_clk          (clk),
        .input_rst          (rst),
        .input_load_shift   (load_shift),
        .input_serial_data  (serial_data),
        .input_ready        (ready),
        .output_word        (word_m),
        .output_valid       (valid_m),
        .output_frame_error (ferr_m),
        .output_overrun     (ovr_m),
        .output_busy        (busy_m)
    );

    serial_word_deframer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .input_clk          (clk),
        .input_rst          (rst),
        .input_load_shift   (load_shift),
        .input_serial_data  (serial_data),
        .input_ready        (ready),
        .output_word        (word_l),
        .output_valid       (valid_l),
        .output_frame_error (ferr_l),
        .output_overrun     (ovr_l),
        .output_busy        (busy_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // b[3] is the first bit on the line.
    task automatic send_bit(input logic b);
        load_shift  = 1'b0;
        serial_data = b;
        tick();
    endtask

    task automatic send_frame(input logic [3:0] b);
        load_shift = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) send_bit(b[3-k]);
    endtask

    initial begin
        rst = 1'b1; load_shift = 1'b0; serial_data = 1'b0; ready = 1'b0;
        tick();
        check("rst_word",  {28'd0, word_m}, 32'h0);
        check("rst_valid", {31'd0, valid_m}, 32'h0);
        check("rst_ferr",  {31'd0, ferr_m}, 32'h0);
        check("rst_ovr",   {31'd0, ovr_m}, 32'h0);
        check("rst_busy",  {31'd0, busy_m}, 32'h0);
        rst = 1'b0;
        tick();
        check("idle_ignore_busy", {31'd0, busy_m}, 32'h0);

        // Basic frame 1,0,1,1 after two load cycles
        load_shift = 1'b1; tick(); tick();
        check("armed_busy", {31'd0, busy_m}, 32'h1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("pre_last_valid", {31'd0, valid_m}, 32'h0);
        send_bit(1'b1);
        check("msb_word",  {28'd0, word_m}, 32'hB);
        check("lsb_word",  {28'd0, word_l}, 32'hD);
        check("f1_valid",  {31'd0, valid_m}, 32'h1);
        check("f1_busy",   {31'd0, busy_m}, 32'h0);
        ready = 1'b1; tick(); ready = 1'b0;
        check("f1_drain", {31'd0, valid_m}, 32'h0);

        // Aborted frame then good frame 0,1,1,0
        load_shift = 1'b1; tick();
        send_bit(1'b1); send_bit(1'b1);
        check("abort_pre_ferr", {31'd0, ferr_m}, 32'h0);
        load_shift = 1'b1; tick();
        check("abort_ferr",  {31'd0, ferr_m}, 32'h1);
        check("abort_valid", {31'd0, valid_m}, 32'h0);
        check("abort_busy",  {31'd0, busy_m}, 32'h1);
        send_bit(1'b0);
        check("abort_ferr_pulse", {31'd0, ferr_m}, 32'h0);
        check("abort_no_valid",   {31'd0, valid_m}, 32'h0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("retry_word",  {28'd0, word_m}, 32'h6);
        check("retry_wordl", {28'd0, word_l}, 32'h6);
        check("retry_valid", {31'd0, valid_m}, 32'h1);
        ready = 1'b1; tick(); ready = 1'b0;

        // Overrun: A pending, 5 dropped
        send_frame(4'hA);
        check("ovr_first", {28'd0, word_m}, 32'hA);
        check("ovr_none_yet", {31'd0, ovr_m}, 32'h0);
        send_frame(4'h5);
        check("ovr_kept",  {28'd0, word_m}, 32'hA);
        check("ovr_keptl", {28'd0, word_l}, 32'h5);
        check("ovr_valid", {31'd0, valid_m}, 32'h1);
        check("ovr_flag",  {31'd0, ovr_m}, 32'h1);
        check("ovr_flagl", {31'd0, ovr_l}, 32'h1);
        ready = 1'b1; tick(); ready = 1'b0;
        check("ovr_drain", {31'd0, valid_m}, 32'h0);
        check("ovr_sticky", {31'd0, ovr_m}, 32'h1);
        tick();
        check("ovr_sticky2", {31'd0, ovr_m}, 32'h1);

        // Clear overrun, then same-edge transfer and load
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst2_ovr", {31'd0, ovr_m}, 32'h0);
        send_frame(4'hC);
        check("pend_word", {28'd0, word_m}, 32'hC);
        load_shift = 1'b1; tick();
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        check("pend_hold", {28'd0, word_m}, 32'hC);
        ready = 1'b1;
        send_bit(1'b1);
        check("same_edge_word",  {28'd0, word_m}, 32'h3);
        check("same_edge_valid", {31'd0, valid_m}, 32'h1);
        check("same_edge_ovr",   {31'd0, ovr_m}, 32'h0);
        tick();
        check("same_edge_drain", {31'd0, valid_m}, 32'h0);
        ready = 1'b0;

        // Async reset mid-frame
        load_shift = 1'b1; tick();
        send_bit(1'b1); send_bit(1'b0);
        check("mid_busy", {31'd0, busy_m}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_word",  {28'd0, word_m}, 32'h0);
        check("async_valid", {31'd0, valid_m}, 32'h0);
        check("async_ferr",  {31'd0, ferr_m}, 32'h0);
        check("async_ovr",   {31'd0, ovr_m}, 32'h0);
        check("async_busy",  {31'd0, busy_m}, 32'h0);
        #2 rst = 1'b0;
        send_frame(4'h9);
        check("post_rst_word",  {28'd0, word_m}, 32'h9);
        check("post_rst_wordl", {28'd0, word_l}, 32'h9);
        check("post_rst_valid", {31'd0, valid_m}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
